// File: rtl/mean_window_3x3.sv
// mean_window_3x3: rounded 3x3 box mean over a raster pixel and its two line-buffer taps.
// Optional frame_err output (short frame / mid-frame resync) under MEAN_WINDOW_FRAME_ERR_EN.
module mean_window_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] data_cur,
    input  logic [DATA_WIDTH-1:0] data_l1,
    input  logic [DATA_WIDTH-1:0] data_l2,
`ifdef MEAN_WINDOW_FRAME_ERR_EN
    output logic                  frame_err,
`endif
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int PW = DATA_WIDTH + 20;

    logic [CW-1:0]         col, cur_col, nxt_col;
    logic [RW-1:0]         row, cur_row, nxt_row;
    logic [DATA_WIDTH+1:0] colsum, cs0, cs1, cs2;
    logic [DATA_WIDTH+3:0] wsum;
    logic [DATA_WIDTH-1:0] mean_c;
    logic                  va, sofa, eola, vb, sofb, eolb, vc, sofc, eolc;

    // in_sof forces the current pixel to (0,0) regardless of the counters
    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
        nxt_col = (cur_col == CW'(IMG_WIDTH - 1)) ? '0 : cur_col + 1'b1;
        nxt_row = (cur_col != CW'(IMG_WIDTH - 1)) ? cur_row :
                  (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
        colsum  = {2'b00, data_cur} + {2'b00, data_l1} + {2'b00, data_l2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            cs0      <= '0;
            cs1      <= '0;
            cs2      <= '0;
            va       <= 1'b0;
            sofa     <= 1'b0;
            eola     <= 1'b0;
            wsum     <= '0;
            vb       <= 1'b0;
            sofb     <= 1'b0;
            eolb     <= 1'b0;
            mean_c   <= '0;
            vc       <= 1'b0;
            sofc     <= 1'b0;
            eolc     <= 1'b0;
            out_valid <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            data_out <= '0;
        end else begin
            if (in_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                cs0 <= colsum;
                cs1 <= cs0;
                cs2 <= cs1;
            end
            // windows touching col<2 are never emitted, so taps left over from the previous line are harmless
            va   <= in_valid && cur_row >= RW'(2) && cur_col >= CW'(2);
            sofa <= in_valid && cur_row == RW'(2) && cur_col == CW'(2);
            eola <= in_valid && cur_row >= RW'(2) && cur_col == CW'(IMG_WIDTH - 1);
            wsum <= {2'b00, cs0} + {2'b00, cs1} + {2'b00, cs2};
            vb   <= va;
            sofb <= sofa;
            eolb <= eola;
            // 7282/65536 approximates 1/9 closely enough to round exactly for DATA_WIDTH <= 10
            mean_c <= DATA_WIDTH'((PW'(wsum) * PW'(7282) + PW'(32768)) >> 16);
            vc   <= vb;
            sofc <= sofb;
            eolc <= eolb;
            out_valid <= vc;
            out_sof  <= sofc;
            out_eol  <= eolc;
            if (vc)
                data_out <= mean_c;
        end
    end

`ifdef MEAN_WINDOW_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else
            frame_err <= in_valid && in_sof && (col != '0 || row != '0);
    end
`endif

endmodule
